// File: rtl/pipeline_types.sv
// Inter-stage payload types and the fetch FSM encoding.
package pipeline_types;

    import rv32_isa::*;

    typedef struct packed {
        logic [31:0]         instruction;
        logic [RegWidth-1:0] pc;
        logic                valid;
    } if_id_t;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_FLUSH = 2'd2
    } if_state_t;

    // Branch/jump targets are forced onto a word boundary.
    function automatic logic [RegWidth-1:0] word_align(input logic [RegWidth-1:0] addr);
        return {addr[RegWidth-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32_isa.sv
// RV32 architectural constants shared by the pipeline stages.
package rv32_isa;

    localparam int RegWidth = 32;

    localparam logic [RegWidth-1:0] PcStep = 32'd4;

endpackage

// File: rtl/if_skid_buf.sv
// Two-entry holding buffer behind the fetch output; head entry is the registered oID.
module if_skid_buf
    import rv32_isa::*;
    import pipeline_types::*;
(
    input  logic       iClk,
    input  logic       nRst,
    input  logic       push,
    input  if_id_t     push_entry,
    input  logic       pop,
    input  logic       flush,
    output if_id_t     head,
    output logic [1:0] count
);

    if_id_t     head_r;
    if_id_t     tail_r;
    logic [1:0] count_r;

    // Entry storage: head is presented downstream, tail is the skid slot.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push) begin
                        head_r  <= push_entry;
                        count_r <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_r <= push_entry;
                    end else if (pop) begin
                        head_r  <= '0;
                        count_r <= 2'd0;
                    end else if (push) begin
                        tail_r  <= push_entry;
                        count_r <= 2'd2;
                    end
                end
                2'd2: begin
                    // Skid entry moves forward on pop so unstall costs no bubble.
                    if (pop) begin
                        head_r <= tail_r;
                        if (push) begin
                            tail_r <= push_entry;
                        end else begin
                            tail_r  <= '0;
                            count_r <= 2'd1;
                        end
                    end
                end
                default: begin
                    head_r  <= '0;
                    tail_r  <= '0;
                    count_r <= 2'd0;
                end
            endcase
        end
    end

    assign head  = head_r;
    assign count = count_r;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC, imem req/ack handshake, redirect and stall handling.
// Optional skid entry behind the output register enabled by IF_SKID_BUFFER_EN.
module if_fetch
    import rv32_isa::*;
    import pipeline_types::*;
#(
    parameter logic [RegWidth-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                iClk,
    input  logic                nRst,
    input  logic                iEn,
    input  logic                iStall,
    input  logic                iRedirect,
    input  logic [RegWidth-1:0] iRedirectPC,
    output logic                oImemReq,
    output logic [RegWidth-1:0] oImemAddr,
    input  logic                iImemAck,
    input  logic [31:0]         iImemData,
    output if_id_t              oID
);

    if_state_t           state_r;
    if_state_t           state_s;
    logic [RegWidth-1:0] pc_r;
    logic [RegWidth-1:0] pc_s;
    logic [RegWidth-1:0] tgt_r;
    logic [RegWidth-1:0] tgt_s;
    logic                req_r;

    if_id_t              head_s;
    if_id_t              push_entry_s;
    logic [RegWidth-1:0] redirect_pc_s;
    logic                pop_s;
    logic                ack_s;
    logic                fetch_ack_s;
    logic                has_space_s;
    logic                push_s;
    logic [1:0]          occ_s;
    logic [1:0]          occ_next_s;
    logic                issue_ok_s;

    assign redirect_pc_s = word_align(iRedirectPC);
    assign pop_s         = iEn && !iStall && head_s.valid;
    assign ack_s         = iImemAck && req_r;
    assign fetch_ack_s   = ack_s && (state_r == IF_FETCH) && !iRedirect;
    assign push_s        = fetch_ack_s && has_space_s;
    assign push_entry_s  = '{instruction: iImemData, pc: pc_r, valid: 1'b1};
    assign occ_next_s    = iRedirect ? 2'd0
                                     : (occ_s + {1'b0, push_s} - {1'b0, pop_s});

`ifdef IF_SKID_BUFFER_EN
    logic [1:0] buf_count_s;

    if_skid_buf u_skid_buf (
        .iClk       (iClk),
        .nRst       (nRst),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (iRedirect),
        .head       (head_s),
        .count      (buf_count_s)
    );

    assign occ_s       = buf_count_s;
    assign has_space_s = (buf_count_s != 2'd2) || pop_s;
    // Any request issued now can always land, because at most one is outstanding.
    assign issue_ok_s  = iEn && (occ_next_s != 2'd2);
`else
    if_id_t oid_r;

    // Single output register; a redirect always wins over a held entry.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            oid_r <= '0;
        end else if (iRedirect) begin
            oid_r <= '0;
        end else if (push_s) begin
            oid_r <= push_entry_s;
        end else if (pop_s) begin
            oid_r <= '0;
        end
    end

    assign head_s      = oid_r;
    assign occ_s       = {1'b0, oid_r.valid};
    assign has_space_s = !oid_r.valid || pop_s;
    // Stop requesting while the output is held; an ack that still finds it held is refetched.
    assign issue_ok_s  = iEn && ((occ_next_s == 2'd0) || !iStall);
`endif

    // Next state, next PC and saved redirect target.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        tgt_s   = tgt_r;
        case (state_r)
            IF_IDLE: begin
                if (iRedirect) begin
                    pc_s = redirect_pc_s;
                end else begin
                    pc_s = pc_r;
                end
                if (issue_ok_s) begin
                    state_s = IF_FETCH;
                end else begin
                    state_s = IF_IDLE;
                end
            end
            IF_FETCH: begin
                if (ack_s) begin
                    if (iRedirect) begin
                        pc_s = redirect_pc_s;
                    end else if (push_s) begin
                        pc_s = pc_r + PcStep;
                    end else begin
                        pc_s = pc_r;
                    end
                    state_s = issue_ok_s ? IF_FETCH : IF_IDLE;
                end else if (iRedirect) begin
                    // Address must not move under an unacknowledged request.
                    tgt_s   = redirect_pc_s;
                    state_s = IF_FLUSH;
                end else begin
                    state_s = IF_FETCH;
                end
            end
            IF_FLUSH: begin
                if (ack_s) begin
                    if (iRedirect) begin
                        pc_s = redirect_pc_s;
                    end else begin
                        pc_s = tgt_r;
                    end
                    state_s = issue_ok_s ? IF_FETCH : IF_IDLE;
                end else if (iRedirect) begin
                    tgt_s   = redirect_pc_s;
                    state_s = IF_FLUSH;
                end else begin
                    state_s = IF_FLUSH;
                end
            end
            default: begin
                state_s = IF_IDLE;
                pc_s    = pc_r;
                tgt_s   = tgt_r;
            end
        endcase
    end

    // FSM, PC and request registers.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_r <= IF_IDLE;
            pc_r    <= RESET_PC;
            tgt_r   <= RESET_PC;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            tgt_r   <= tgt_s;
            req_r   <= (state_s != IF_IDLE);
        end
    end

    assign oImemReq  = req_r;
    assign oImemAddr = pc_r;
    assign oID       = head_s;

endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch against a queue-based fetch model, plus directed cases.
module tb_if_fetch;

    import rv32_isa::*;
    import pipeline_types::*;

`ifdef IF_SKID_BUFFER_EN
    localparam int Cap = 2;
`else
    localparam int Cap = 1;
`endif

    logic        iClk;
    logic        nRst;
    logic        iEn;
    logic        iStall;
    logic        iRedirect;
    logic [31:0] iRedirectPC;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemAck;
    logic [31:0] iImemData;
    if_id_t      oID;

    logic        n2Rst;
    logic        en2;
    logic        ack2_en;
    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] data2;
    if_id_t      id2;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;
    bit done2    = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_flush;
    logic [31:0] m_tgt;

    int mem_cnt   = 0;
    int mem_wait  = 0;
    int fix_wait  = 0;
    bit rand_wait = 0;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .iClk(iClk), .nRst(nRst), .iEn(iEn), .iStall(iStall),
        .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
        .oImemReq(oImemReq), .oImemAddr(oImemAddr),
        .iImemAck(iImemAck), .iImemData(iImemData), .oID(oID)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .iClk(iClk), .nRst(n2Rst), .iEn(en2), .iStall(1'b0),
        .iRedirect(1'b0), .iRedirectPC(32'h0000_0000),
        .oImemReq(req2), .oImemAddr(addr2),
        .iImemAck(ack2), .iImemData(data2), .oID(id2)
    );

    assign ack2  = ack2_en && req2;
    assign data2 = addr2 ^ 32'hA5A5_0000;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_req   = 1'b0;
        m_addr  = 32'h0000_0000;
        m_flush = 1'b0;
        m_tgt   = 32'h0000_0000;
    endtask

    // One clock edge of the fetch rules, evaluated on the inputs of the cycle just ended.
    task automatic model_step();
        int   sz;
        bit   pop;
        bit   ackv;
        ent_t e;
        if (!nRst) begin
            model_reset();
            return;
        end
        sz   = m_q.size();
        pop  = iEn && !iStall && (sz > 0);
        ackv = iImemAck && m_req;
        if (iRedirect) begin
            m_q.delete();
            if (m_req && !ackv) begin
                m_flush = 1'b1;
                m_tgt   = iRedirectPC & 32'hFFFF_FFFC;
            end else begin
                m_addr  = iRedirectPC & 32'hFFFF_FFFC;
                m_flush = 1'b0;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (ackv) begin
                if (m_flush) begin
                    m_addr  = m_tgt;
                    m_flush = 1'b0;
                end else if (sz < Cap || pop) begin
                    e.ins = m_addr ^ 32'hA5A5_0000;
                    e.pc  = m_addr;
                    m_q.push_back(e);
                    m_addr = m_addr + 32'd4;
                end
            end
        end
        if (!m_req || ackv) begin
`ifdef IF_SKID_BUFFER_EN
            m_req = iEn && (m_q.size() < 2);
`else
            m_req = iEn && ((m_q.size() == 0) || !iStall);
`endif
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(negedge iClk) begin
        if (chk_en) begin
            check("imem_req", {31'd0, oImemReq}, {31'd0, m_req});
            check("imem_addr", oImemAddr, m_addr);
            check("id_valid", {31'd0, oID.valid}, {31'd0, (m_q.size() > 0)});
            if (m_q.size() > 0) begin
                check("id_pc", oID.pc, m_q[0].pc);
                check("id_instr", oID.instruction, m_q[0].ins);
            end
        end
    end

    // Drive one cycle from just after a negedge, step the model at the posedge.
    task automatic step(input logic en, input logic stall, input logic redir, input logic [31:0] tgt);
        logic req_now;
        iEn         = en;
        iStall      = stall;
        iRedirect   = redir;
        iRedirectPC = tgt;
        req_now     = oImemReq;
        iImemAck    = req_now && (mem_cnt >= mem_wait);
        iImemData   = oImemAddr ^ 32'hA5A5_0000;
        @(posedge iClk);
        model_step();
        if (iImemAck) begin
            mem_cnt  = 0;
            mem_wait = rand_wait ? int'($urandom_range(0, 3)) : fix_wait;
        end else if (req_now) begin
            mem_cnt++;
        end
        @(negedge iClk);
    endtask

    task automatic do_reset();
        #2;
        nRst = 1'b0;
        model_reset();
        mem_cnt  = 0;
        mem_wait = fix_wait;
        #1;
        check("rst_req", {31'd0, oImemReq}, 32'd0);
        check("rst_valid", {31'd0, oID.valid}, 32'd0);
        check("rst_addr", oImemAddr, 32'h0000_0000);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        nRst = 1'b1;
    endtask

    initial begin
        logic [31:0] p;
        bit          found;
        int          last_v;
        int          gap;
        int          nv;
        nRst = 1'b0; iEn = 1'b0; iStall = 1'b0; iRedirect = 1'b0;
        iRedirectPC = 32'd0; iImemAck = 1'b0; iImemData = 32'd0;
        model_reset();
        chk_en = 1'b1;
        @(negedge iClk);

        // Reset release and zero-wait streaming
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("first_req", {31'd0, oImemReq}, 32'd1);
        check("first_addr", oImemAddr, 32'h0000_0000);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("s0_valid", {31'd0, oID.valid}, 32'd1);
        check("s0_pc", oID.pc, 32'h0000_0000);
        check("s0_instr", oID.instruction, 32'hA5A5_0000);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("s1_pc", oID.pc, 32'h0000_0004);
        check("s1_instr", oID.instruction, 32'hA5A5_0004);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("s2_pc", oID.pc, 32'h0000_0008);

        // Three wait states per request
        fix_wait = 3;
        last_v = -1; gap = 0; nv = 0;
        for (int c = 0; c < 24; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            if (oID.valid) begin
                if (last_v >= 0) gap = c - last_v;
                last_v = c;
                nv++;
            end
        end
        check("slow_gap", gap, 32'd4);

        // Redirect in the ack cycle of the fetch at 0x10
        fix_wait = 0;
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (oImemReq && oImemAddr == 32'h0000_0010) begin
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b0, 1'b0, 32'd0);
        end
        check("find_0x10", {31'd0, found}, 32'd1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0102);
        check("redir_valid", {31'd0, oID.valid}, 32'd0);
        check("redir_addr", oImemAddr, 32'h0000_0100);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("redir_pc", oID.pc, 32'h0000_0100);

        // Redirect while a request is pending
        fix_wait = 2;
        step(1'b1, 1'b0, 1'b1, 32'h0000_0020);
        check("pend_addr0", oImemAddr, 32'h0000_0020);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0040);
        check("pend_addr1", oImemAddr, 32'h0000_0020);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("pend_addr2", oImemAddr, 32'h0000_0020);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("pend_addr3", oImemAddr, 32'h0000_0040);
        check("pend_valid", {31'd0, oID.valid}, 32'd0);
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            if (oID.valid) begin
                found = 1'b1;
                break;
            end
        end
        check("pend_seen", {31'd0, found}, 32'd1);
        check("pend_pc", oID.pc, 32'h0000_0040);

        // Five-cycle stall mid-stream
        fix_wait = 0;
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 1'b0, 32'd0);
        check("pre_stall_valid", {31'd0, oID.valid}, 32'd1);
        p = oID.pc;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            check("stall_hold", oID.pc, p);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0);
`ifdef IF_SKID_BUFFER_EN
        check("unstall_pc", oID.pc, p + 32'd4);
        check("unstall_valid", {31'd0, oID.valid}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("unstall_next", oID.pc, p + 32'd8);
`else
        check("unstall_bubble", {31'd0, oID.valid}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("unstall_next", oID.pc, p + 32'd4);
`endif

        // Randomised traffic with a reset in the middle
        rand_wait = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 19) == 0),
                 32'($urandom_range(0, 511)));
        end

        for (int c = 0; c < 100 && !done2; c++) @(negedge iClk);
        check("wrap_done", {31'd0, done2}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // PC wrap-around and reset during a pending request on the second instance
    initial begin
        logic [31:0] exp_pc [4];
        logic [31:0] held;
        int          idx;
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        exp_pc[3] = 32'h0000_0004;
        n2Rst = 1'b0; en2 = 1'b0; ack2_en = 1'b1;
        repeat (2) @(negedge iClk);
        n2Rst = 1'b1;
        en2   = 1'b1;
        idx   = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge iClk);
            if (id2.valid) begin
                check("wrap_pc", id2.pc, exp_pc[idx]);
                check("wrap_instr", id2.instruction, exp_pc[idx] ^ 32'hA5A5_0000);
                idx++;
            end
        end
        check("wrap_count", idx, 32'd4);
        ack2_en = 1'b0;
        held    = addr2;
        repeat (2) @(negedge iClk);
        check("wait_req", {31'd0, req2}, 32'd1);
        check("wait_addr", addr2, held);
        #2;
        n2Rst = 1'b0;
        #1;
        check("midrst_req", {31'd0, req2}, 32'd0);
        check("midrst_valid", {31'd0, id2.valid}, 32'd0);
        check("midrst_addr", addr2, 32'hFFFF_FFF8);
        @(negedge iClk);
        n2Rst = 1'b1;
        en2   = 1'b0;
        done2 = 1'b1;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction Fetch stage: the producer side of the `if_id_t` interface consumed by the decode stage. Holds the program counter, issues word requests to instruction memory over a req/ack handshake, and presents one fetched instruction per cycle to decode. Honours pipeline stall and enable, and redirects the PC on a taken branch or jump reported from downstream.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `iClk`  in  1  clock; all state updates on the rising edge.
- `nRst`  in  1  asynchronous, active-low reset.
- `iEn`  in  1  global enable; low behaves as a stall and issues no new request.
- `iStall`  in  1  decode not accepting; `oID` holds.
- `iRedirect`  in  1  taken branch/jump; one-cycle pulse.
- `iRedirectPC`  in  RegWidth  redirect target; bits [1:0] forced to 0.
- `oImemReq`  out  1  request valid.
- `oImemAddr`  out  RegWidth  word address; stable while `oImemReq` is high and no ack has arrived.
- `iImemAck`  in  1  request accepted; `iImemData` is valid this same cycle.
- `iImemData`  in  32  instruction word.
- `oID`  out  `if_id_t`  fields `instruction`, `pc`, `valid`.

## Operation
- Reset values: `oID` = '0, so `valid` = 0; `oImemReq` = 0; `oImemAddr` = `RESET_PC`; PC = `RESET_PC`; FSM in IDLE; buffer empty.
- FSM states:
  - IDLE: `oImemReq` = 0. Go to FETCH when `iEn` is high and buffer space exists.
  - FETCH: `oImemReq` = 1. On ack with no redirect: capture data, PC += 4, stay in FETCH if space remains, else go to IDLE.
  - FLUSH: `oImemReq` = 1, held on the old address. On ack: discard data, PC = saved target, go to FETCH.
- Accepting an output: an entry is consumed on each edge where `iEn` && !`iStall` && `oID.valid`.
- Buffer space: output register only, or output register plus skid entry (see Configuration).
- Redirect in IDLE or FETCH, same cycle as ack: data dropped, PC = target.
- Redirect in FETCH with no ack this cycle: save target, go to FLUSH. The address is never changed mid-request.
- Every redirect clears `oID.valid` and the skid entry on the next edge.
- Redirect beats stall when both are high.
- A second redirect while in FLUSH overwrites the saved target.
- PC wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- `nRst` asserted mid-request: all state returns to reset values at once; any late ack is ignored because `oImemReq` = 0.

## Timing
- `oImemReq` is registered and first asserts after the first rising edge with `nRst` high and `iEn` high.
- Ack at edge N → instruction appears on `oID` after edge N, and the next request (PC+4) is driven from edge N.
- With zero-wait memory (`iImemAck` = 1 whenever `oImemReq` is high), throughput is 1 instruction per cycle.
- Redirect at edge N:
  - Idle, or ack at N: first request to the target is driven after N.
  - Pending request at N: target request is driven after the old request's ack.
- Stall: `oID` holds all fields unchanged for every stalled cycle.

## Configuration
- `IF_SKID_BUFFER_EN` defined:
  - One extra entry behind the output register.
  - A request in flight when stall rises is captured into the skid entry.
  - Fetch continues until both entries are full.
  - On unstall, the skid entry moves to `oID` with no bubble.
- Not defined:
  - No new request is issued while `oID.valid` && (`iStall` || !`iEn`).
  - An ack arriving while `oID` is held still needs a place, so fetch stops requesting one cycle early: a request is issued only when the output register will be free. This costs one bubble after each stall.

## Structure
- `pipeline_types` holds `if_id_t` (`instruction[31:0]`, `pc[RegWidth-1:0]`, `valid`) and the FSM state enum `if_state_t`.
- `rv32_isa` supplies `RegWidth`.
- One sub-module: `if_skid_buf`, a 2-entry holding buffer with count, push, pop and flush. It is instantiated only under `IF_SKID_BUFFER_EN`.

## Test plan
- Reset release, `RESET_PC` = 0, zero-wait memory returning addr^32'hA5A5_0000 → `oID.pc` = 0, 4, 8, … on consecutive cycles, each `instruction` matching.
- Ack delayed 3 cycles per request → `oImemAddr` stable across the wait, `oID.valid` low until ack, one instruction per 4 cycles.
- `iRedirect` with target 32'h0000_0102 in the ack cycle of the fetch at 0x10 → data from 0x10 never valid; next address 32'h0000_0100.
- Redirect to 0x40 while the request to 0x20 is pending (ack 2 cycles later) → 0x20 data discarded, next request 0x40, then `oID.pc` = 0x40.
- `iStall` high for 5 cycles mid-stream → `oID` frozen. With `IF_SKID_BUFFER_EN`, the next pc follows without a bubble on release; without it, one bubble.
- `RESET_PC` = 32'hFFFF_FFF8 → pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; `nRst` pulsed mid-wait → `oImemReq` = 0 and `oID.valid` = 0 immediately.
